if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage of the 5-stage pipeline, directly upstream of the decode stage. It holds the program counter and drives the instruction-memory address. It selects the next PC from pc+4 or the branch/jump targets returned by decode, and registers pc+4 and the fetched instruction into the IF/ID pipeline register. It honours the load-use stall from the hazard unit and counts stall and flush cycles for bring-up.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- NOP_INST, 32'h0000_0000, instruction word injected into IF/ID on reset and on flush.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- clr  in  1  asynchronous, active-high reset.
- stall  in  1  hazard-unit stall; holds PC and IF/ID when 1.
- pcsource  in  2  next-PC select from decode: 00 pc+4, 01 bpc, 10 jpc, 11 pc+4.
- bpc  in  32  branch target from decode.
- jpc  in  32  jump target from decode.
- imem_data  in  32  instruction word at imem_addr; combinational, same cycle.
- imem_addr  out  32  current fetch PC.
- id_pc4  out  32  IF/ID register: pc+4 of the instruction in decode.
- id_inst  out  32  IF/ID register: instruction in decode.
- stall_cnt  out  32  number of cycles with stall=1 since reset.
- flush_cnt  out  32  number of IF/ID flushes since reset.

## Operation
- pc4 = pc + 4, computed modulo 2^32; wrap from 32'hFFFF_FFFC to 0 is legal.
- Next PC:
  - pcsource 00 or 11: pc4.
  - pcsource 01: {bpc[31:2],2'b00}.
  - pcsource 10: {jpc[31:2],2'b00}.
- Target low bits are forced to 0, so imem_addr[1:0] is always 0.
- stall=1:
  - pc, id_pc4 and id_inst all hold.
  - pcsource is ignored that cycle. Decode re-presents the same instruction next cycle, so the redirect is not lost.
  - stall_cnt increments.
- stall=0, pcsource 00/11:
  - pc <= pc4.
  - id_pc4 <= pc4.
  - id_inst <= imem_data.
- stall=0, pcsource 01/10 (redirect):
  - pc <= target.
  - IF/ID handling depends on IF_BRANCH_FLUSH_EN (see Configuration).
- Counters wrap modulo 2^32, never saturate.
- flush_cnt increments only when a flush is actually applied.
- Reset (asynchronous, any time, including mid-stall or mid-redirect):
  - pc = RESET_PC, so imem_addr = RESET_PC.
  - id_pc4 = 0.
  - id_inst = NOP_INST.
  - stall_cnt = 0, flush_cnt = 0.
- After clr deasserts, the first rising edge with stall=0 fetches from RESET_PC.

## Timing
- Fetch-to-decode latency: 1 cycle. The word read at imem_addr in cycle N appears on id_inst in cycle N+1.
- Redirect latency: pcsource/bpc/jpc sampled at edge E; imem_addr equals the target immediately after E.
- Exactly one instruction, the fall-through word fetched in the redirect cycle, is latched or squashed at E.
- All outputs are registered; no combinational path from any input to any output except none: imem_addr is the pc register.
- Simultaneous stall and redirect: stall wins, with no redirect and no flush count.

## Configuration
- IF_BRANCH_FLUSH_EN defined:
  - On a redirect with stall=0, id_inst <= NOP_INST and id_pc4 <= pc4.
  - flush_cnt increments. This gives no delay slot.
- IF_BRANCH_FLUSH_EN undefined:
  - On a redirect, IF/ID loads the fall-through word normally (branch delay slot architecture).
  - flush_cnt stays 0 permanently.

## Test plan
- Reset then free-run:
  - clr pulse, stall=0, pcsource=00, RESET_PC=0.
  - imem_addr goes 0,4,8,C.
  - id_inst lags by one cycle with id_pc4 = address+4.
  - All outputs are 0/NOP during clr.
- Branch redirect:
  - At pc=8, drive pcsource=01, bpc=32'h40.
  - Next cycle imem_addr=32'h40.
  - With macro: id_inst=NOP, flush_cnt=1.
  - Without macro: id_inst=word@8, flush_cnt=0.
- Jump with misaligned target:
  - pcsource=10, jpc=32'h0000_0107.
  - imem_addr=32'h0000_0104.
- Load-use stall:
  - stall=1 for 2 cycles at pc=C.
  - imem_addr, id_inst and id_pc4 are unchanged for both cycles; stall_cnt=2.
  - Fetch resumes at C then 10.
- Stall plus redirect:
  - stall=1 and pcsource=01 in the same cycle: pc holds, flush_cnt is unchanged.
  - Next cycle stall=0 with pcsource=01: redirect is taken.
- Wrap and mid-operation reset:
  - Force pc=32'hFFFF_FFFC and clock: imem_addr=0, id_pc4=0.
  - Assert clr asynchronously between edges: outputs go to reset values immediately, without waiting for clk.

Source files
------------

// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage: instruction-fetch stage of the 5-stage pipeline.
//
// Holds the program counter, drives the instruction-memory address and loads
// the IF/ID pipeline register with pc+4 and the fetched word.  Honours the
// load-use stall from the hazard unit and keeps bring-up counters for stall
// and flush cycles.
//
// Optional feature macro: IF_BRANCH_FLUSH_EN
//   defined   : a taken redirect squashes the fall-through word in IF/ID
//               (NOP_INST is loaded) and flush_cnt counts those squashes.
//   undefined : the fall-through word is kept (branch delay slot) and
//               flush_cnt stays at zero.
// ---------------------------------------------------------------------------
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        stall,
    input  logic [1:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] jpc,
    input  logic [31:0] imem_data,
    output logic [31:0] imem_addr,
    output logic [31:0] id_pc4,
    output logic [31:0] id_inst,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    logic [31:0] pc_q,       pc_d;
    logic [31:0] idPc4_q,    idPc4_d;
    logic [31:0] idInst_q,   idInst_d;
    logic [31:0] stallCnt_q, stallCnt_d;
    logic [31:0] flushCnt_q, flushCnt_d;

    logic [31:0] pc4;
    logic [31:0] target;
    logic        redirect;

    // Sequential pc+4 (wraps naturally at 2^32) and the word-aligned
    // redirect target chosen by decode.
    always_comb begin
        pc4      = pc_q + 32'd4;
        redirect = 1'b0;
        target   = pc4;
        unique case (pcsource)
            2'b01: begin
                redirect = 1'b1;
                target   = {bpc[31:2], 2'b00};
            end
            2'b10: begin
                redirect = 1'b1;
                target   = {jpc[31:2], 2'b00};
            end
            default: begin
                redirect = 1'b0;
                target   = pc4;
            end
        endcase
    end

    // Next-state for PC, IF/ID and counters; a stall freezes everything
    // and discards the redirect, since decode will present it again.
    always_comb begin
        pc_d       = pc_q;
        idPc4_d    = idPc4_q;
        idInst_d   = idInst_q;
        stallCnt_d = stallCnt_q;
        flushCnt_d = flushCnt_q;
        if (stall) begin
            stallCnt_d = stallCnt_q + 32'd1;
        end else begin
            pc_d     = target;
            idPc4_d  = pc4;
            idInst_d = imem_data;
`ifdef IF_BRANCH_FLUSH_EN
            if (redirect) begin
                idInst_d   = NOP_INST;
                flushCnt_d = flushCnt_q + 32'd1;
            end
`endif
        end
    end

    // State registers with asynchronous reset to the power-on fetch state.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            pc_q       <= RESET_PC;
            idPc4_q    <= 32'h0000_0000;
            idInst_q   <= NOP_INST;
            stallCnt_q <= 32'h0000_0000;
            flushCnt_q <= 32'h0000_0000;
        end else begin
            pc_q       <= pc_d;
            idPc4_q    <= idPc4_d;
            idInst_q   <= idInst_d;
            stallCnt_q <= stallCnt_d;
            flushCnt_q <= flushCnt_d;
        end
    end

    assign imem_addr = pc_q;
    assign id_pc4    = idPc4_q;
    assign id_inst   = idInst_q;
    assign stall_cnt = stallCnt_q;
    assign flush_cnt = flushCnt_q;

endmodule

// File: tb/tb_if_stage.sv
// ---------------------------------------------------------------------------
// tb_if_stage: directed self-checking bench for if_stage.
// A fetch model tracks the architectural PC, IF/ID contents and counters
// from the redirect/stall rules; a negedge compare process checks the DUT
// against it every cycle, and literal checks pin key points of the model.
// ---------------------------------------------------------------------------
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk;
    logic        clr;
    logic        stall;
    logic [1:0]  pcsource;
    logic [31:0] bpc;
    logic [31:0] jpc;
    logic [31:0] imem_data;
    logic [31:0] imem_addr;
    logic [31:0] id_pc4;
    logic [31:0] id_inst;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    int tests;
    int fails;
    bit checkEn;

    // Model of the architectural fetch state
    logic [31:0] mPc;
    logic [31:0] mPc4;
    logic [31:0] mInst;
    logic [31:0] mStalls;
    logic [31:0] mFlushes;

    if_stage #(
        .RESET_PC (32'h0000_0000),
        .NOP_INST (NOP)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .stall     (stall),
        .pcsource  (pcsource),
        .bpc       (bpc),
        .jpc       (jpc),
        .imem_data (imem_data),
        .imem_addr (imem_addr),
        .id_pc4    (id_pc4),
        .id_inst   (id_inst),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );

    // Instruction memory contents: a distinct word for every address
    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (a * 32'd3) + 32'h1300_0013;
    endfunction

    assign imem_data = memWord(imem_addr);

    // 10-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always terminates
    initial begin
        #20000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic modelReset();
        mPc      = 32'h0000_0000;
        mPc4     = 32'h0000_0000;
        mInst    = NOP;
        mStalls  = 32'h0000_0000;
        mFlushes = 32'h0000_0000;
    endtask

    // One architectural clock step of the fetch stage
    task automatic modelEdge(input logic st, input logic [1:0] ps,
                             input logic [31:0] b, input logic [31:0] j);
        logic [31:0] fetched;
        logic        taken;
        if (st) begin
            mStalls = mStalls + 1;
        end else begin
            fetched = memWord(mPc);
            taken   = (ps == 2'b01) || (ps == 2'b10);
            mPc4    = mPc + 4;
`ifdef IF_BRANCH_FLUSH_EN
            mInst   = taken ? NOP : fetched;
            if (taken) mFlushes = mFlushes + 1;
`else
            mInst   = fetched;
`endif
            if (ps == 2'b01)      mPc = b & ~32'd3;
            else if (ps == 2'b10) mPc = j & ~32'd3;
            else                  mPc = mPc + 4;
        end
    endtask

    task automatic applyStimulus(input logic st, input logic [1:0] ps,
                                 input logic [31:0] b, input logic [31:0] j);
        stall    = st;
        pcsource = ps;
        bpc      = b;
        jpc      = j;
        @(posedge clk);
        modelEdge(st, ps, b, j);
        @(negedge clk);
    endtask

    // Every-cycle comparison of the DUT against the model
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("cyc imem_addr", imem_addr, mPc);
            checkOutput("cyc id_pc4", id_pc4, mPc4);
            checkOutput("cyc id_inst", id_inst, mInst);
            checkOutput("cyc stall_cnt", stall_cnt, mStalls);
            checkOutput("cyc flush_cnt", flush_cnt, mFlushes);
        end
    end

    // Directed scenario sequence
    initial begin
        tests    = 0;
        fails    = 0;
        clr      = 1'b1;
        stall    = 1'b0;
        pcsource = 2'b00;
        bpc      = 32'h0;
        jpc      = 32'h0;
        modelReset();
        checkEn  = 1'b1;

        #2;
        checkOutput("reset imem_addr", imem_addr, 32'h0);
        checkOutput("reset id_inst", id_inst, NOP);
        checkOutput("reset id_pc4", id_pc4, 32'h0);
        checkOutput("reset stall_cnt", stall_cnt, 32'h0);
        checkOutput("reset flush_cnt", flush_cnt, 32'h0);
        @(negedge clk);
        @(negedge clk);
        clr = 1'b0;

        // Free run: 0 -> 4 -> 8
        applyStimulus(1'b0, 2'b00, 32'h0, 32'h0);
        checkOutput("run1 imem_addr", imem_addr, 32'h4);
        checkOutput("run1 id_inst", id_inst, 32'h1300_0013);
        checkOutput("run1 id_pc4", id_pc4, 32'h4);
        applyStimulus(1'b0, 2'b11, 32'h0, 32'h0);
        checkOutput("run2 imem_addr", imem_addr, 32'h8);
        checkOutput("run2 id_inst", id_inst, 32'h1300_001F);

        // Branch at pc=8 to 0x40
        applyStimulus(1'b0, 2'b01, 32'h40, 32'h0);
        checkOutput("branch imem_addr", imem_addr, 32'h40);
        checkOutput("branch id_pc4", id_pc4, 32'hC);
`ifdef IF_BRANCH_FLUSH_EN
        checkOutput("branch id_inst", id_inst, NOP);
        checkOutput("branch flush_cnt", flush_cnt, 32'h1);
`else
        checkOutput("branch id_inst", id_inst, 32'h1300_002B);
        checkOutput("branch flush_cnt", flush_cnt, 32'h0);
`endif

        // Jump to misaligned target
        applyStimulus(1'b0, 2'b10, 32'h0, 32'h0000_0107);
        checkOutput("jump imem_addr", imem_addr, 32'h0000_0104);

        // Jump to 0xC, then load-use stall for two cycles
        applyStimulus(1'b0, 2'b10, 32'h0, 32'h0000_000C);
        applyStimulus(1'b0, 2'b00, 32'h0, 32'h0);
        applyStimulus(1'b0, 2'b10, 32'h0, 32'h0000_000C);
        applyStimulus(1'b1, 2'b00, 32'h0, 32'h0);
        applyStimulus(1'b1, 2'b00, 32'h0, 32'h0);
        checkOutput("stall imem_addr", imem_addr, 32'hC);
        checkOutput("stall stall_cnt", stall_cnt, 32'h2);
        applyStimulus(1'b0, 2'b00, 32'h0, 32'h0);
        checkOutput("resume imem_addr", imem_addr, 32'h10);
        checkOutput("resume id_inst", id_inst, 32'h1300_0037);
        checkOutput("resume id_pc4", id_pc4, 32'h10);

        // Stall together with redirect: stall wins, then redirect taken
        applyStimulus(1'b1, 2'b01, 32'h80, 32'h0);
        checkOutput("stallbr imem_addr", imem_addr, 32'h10);
        checkOutput("stallbr stall_cnt", stall_cnt, 32'h3);
        applyStimulus(1'b0, 2'b01, 32'h80, 32'h0);
        checkOutput("stallbr2 imem_addr", imem_addr, 32'h80);

        // Wrap from 0xFFFF_FFFC
        applyStimulus(1'b0, 2'b10, 32'h0, 32'hFFFF_FFFF);
        checkOutput("wrap0 imem_addr", imem_addr, 32'hFFFF_FFFC);
        applyStimulus(1'b0, 2'b00, 32'h0, 32'h0);
        checkOutput("wrap imem_addr", imem_addr, 32'h0);
        checkOutput("wrap id_pc4", id_pc4, 32'h0);

        // Mixed pattern table
        for (int i = 0; i < 8; i++) begin
            applyStimulus(i[0] & i[1], 2'(i % 4), 32'h0000_0200 + 32'(i * 8),
                          32'h0000_0303 + 32'(i * 16));
        end

        // Asynchronous reset between clock edges
        @(posedge clk);
        #3;
        clr = 1'b1;
        modelReset();
        #1;
        checkOutput("async imem_addr", imem_addr, 32'h0);
        checkOutput("async id_pc4", id_pc4, 32'h0);
        checkOutput("async id_inst", id_inst, NOP);
        checkOutput("async stall_cnt", stall_cnt, 32'h0);
        checkOutput("async flush_cnt", flush_cnt, 32'h0);
        @(negedge clk);
        clr = 1'b0;
        applyStimulus(1'b0, 2'b00, 32'h0, 32'h0);
        checkOutput("post imem_addr", imem_addr, 32'h4);
        checkOutput("post id_inst", id_inst, 32'h1300_0013);

        checkEn = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
